// File: rtl/sobel_window_ctrl_pkg.sv
// Shared definitions for the Sobel window controller: FSM encoding, pixel width
// default and the gradient-magnitude threshold used by the Sobel core.
package sobel_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int unsigned PIX_W_DEF   = 8;
    // |Gx|+|Gy| strictly above this value marks an edge
    localparam int unsigned EDGE_THRESH = 128;

endpackage

// File: rtl/sobel_window_ctrl_core.sv
// Combinational 3x3 Sobel core: |Gx| + |Gy| compared against EDGE_THRESH.
module sobel_window_ctrl_core
    import sobel_window_ctrl_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic [PIX_W-1:0] mat00,
    input  logic [PIX_W-1:0] mat01,
    input  logic [PIX_W-1:0] mat02,
    input  logic [PIX_W-1:0] mat10,
    input  logic [PIX_W-1:0] mat11,
    input  logic [PIX_W-1:0] mat12,
    input  logic [PIX_W-1:0] mat20,
    input  logic [PIX_W-1:0] mat21,
    input  logic [PIX_W-1:0] mat22,
    output logic             out
);

    // 4 guard bits cover the x4 weighted sum plus sign
    localparam int unsigned GW = PIX_W + 4;

    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic        [GW-1:0] w_ax;
    logic        [GW-1:0] w_ay;
    logic        [GW:0]   w_mag;
    logic                 w_unused_centre;

    function automatic logic signed [GW-1:0] sx(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    assign w_gx = (sx(mat02) + (sx(mat12) <<< 1) + sx(mat22))
                - (sx(mat00) + (sx(mat10) <<< 1) + sx(mat20));
    assign w_gy = (sx(mat20) + (sx(mat21) <<< 1) + sx(mat22))
                - (sx(mat00) + (sx(mat01) <<< 1) + sx(mat02));

    assign w_ax  = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    assign w_ay  = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    assign out   = (w_mag > (GW+1)'(EDGE_THRESH));

    // the centre tap carries zero weight in both kernels
    assign w_unused_centre = ^mat11;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-stream Sobel window controller: two line buffers, a sliding 3x3 window
// and a frame FSM issuing one registered edge bit per interior pixel.
module sobel_window_ctrl
    import sobel_window_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic                     out_edge,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    state_t             r_state;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [PIX_W-1:0]   r_lb1 [IMG_W];
    logic [PIX_W-1:0]   r_lb2 [IMG_W];
    logic [PIX_W-1:0]   r_wa  [3];
    logic [PIX_W-1:0]   r_wb  [3];

    logic               w_accept;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_interior;
    logic               w_edge;
    logic [PIX_W-1:0]   w_top;
    logic [PIX_W-1:0]   w_mid;

    assign w_accept   = in_ready && in_valid;
    assign w_last_col = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
    assign w_interior = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_top      = r_lb2[r_col];
    assign w_mid      = r_lb1[r_col];

    // Window: r_wa = column c-2, r_wb = column c-1, live column c from buffers/input
    sobel_window_ctrl_core #(.PIX_W(PIX_W)) u_core (
        .mat00 (r_wa[0]), .mat01 (r_wb[0]), .mat02 (w_top),
        .mat10 (r_wa[1]), .mat11 (r_wb[1]), .mat12 (w_mid),
        .mat20 (r_wa[2]), .mat21 (r_wb[2]), .mat22 (in_pixel),
        .out   (w_edge)
    );

    // Line buffers need no reset: every entry is rewritten before it is read for output
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_edge  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            for (int i = 0; i < 3; i++) begin
                r_wa[i] <= '0;
                r_wb[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_STREAM;
                        r_row    <= '0;
                        r_col    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            r_wa[i] <= '0;
                            r_wb[i] <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (in_ready) begin
                        if (in_valid) begin
                            for (int i = 0; i < 3; i++) r_wa[i] <= r_wb[i];
                            r_wb[0] <= w_top;
                            r_wb[1] <= w_mid;
                            r_wb[2] <= in_pixel;
                            if (w_interior) begin
                                out_valid <= 1'b1;
                                out_edge  <= w_edge;
                                out_row   <= r_row - ROW_W'(1);
                                out_col   <= r_col - COL_W'(1);
                            end
                            if (w_last_col) begin
                                r_col <= '0;
                                if (w_last_row) in_ready <= 1'b0;
                                else            r_row    <= r_row + ROW_W'(1);
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end else begin
                        // final pixel's output has issued; close the frame
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
